// File: rtl/level_pkg.sv
// Shared definitions for the Frogger level-up path: FSM state encoding and the
// level bus width common to the detector and the level counter.
package level_pkg;

   localparam int DEFAULT_LEVEL_WIDTH = 2;

   typedef logic [2:0] levelState_t;

   localparam levelState_t IDLE    = 3'd0;
   localparam levelState_t HOLD    = 3'd1;
   localparam levelState_t PULSE   = 3'd2;
   localparam levelState_t RESPAWN = 3'd3;
   localparam levelState_t WON     = 3'd4;

endpackage

// File: rtl/level_hold_timer.sv
// Hold-time counter: synchronous clear and enable, flags the last hold cycle.
// The done flag gates the enable in the parent, so the count stops at HOLD_CYCLES-1.
module level_hold_timer #(
   parameter int HOLD_CYCLES = 25000000,
   parameter int HOLD_WIDTH  = 25
)(
   input  logic SC_HOLDTIMER_CLOCK_50,
   input  logic SC_HOLDTIMER_RESET_InHigh,
   input  logic SC_HOLDTIMER_clear_InHigh,
   input  logic SC_HOLDTIMER_enable_InHigh,
   output logic SC_HOLDTIMER_done_OutHigh
);

   localparam logic [HOLD_WIDTH-1:0] LAST_COUNT = HOLD_WIDTH'(HOLD_CYCLES - 1);

   logic [HOLD_WIDTH-1:0] countReg;

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge SC_HOLDTIMER_CLOCK_50) begin
      if (SC_HOLDTIMER_RESET_InHigh || SC_HOLDTIMER_clear_InHigh) begin
         countReg <= '0;
      end else if (SC_HOLDTIMER_enable_InHigh) begin
         countReg <= countReg + 1'b1;
      end
   end

   assign SC_HOLDTIMER_done_OutHigh = (countReg == LAST_COUNT);

endmodule

// File: rtl/level_up_detector.sv
// Frogger level-up detector: a frog held alive on the goal row emits one active-low
// upcount pulse and a respawn request, or latches game-won at the top level.
module level_up_detector
   import level_pkg::*;
#(
   parameter int ROW_WIDTH   = 4,
   parameter int GOAL_ROW    = 0,
   parameter int START_ROW   = 15,
   parameter int HOLD_CYCLES = 25000000,
   parameter int HOLD_WIDTH  = 25,
   parameter int LEVEL_WIDTH = DEFAULT_LEVEL_WIDTH
)(
   input  logic                   SC_LEVELUP_CLOCK_50,
   input  logic                   SC_LEVELUP_RESET_InHigh,
   input  logic [ROW_WIDTH-1:0]   SC_LEVELUP_frogRow_InBUS,
   input  logic                   SC_LEVELUP_frogAlive_InHigh,
   input  logic [LEVEL_WIDTH-1:0] SC_LEVELUP_level_InBUS,
   output logic                   SC_LEVELUP_upcount_OutLow,
   output logic                   SC_LEVELUP_frogRestart_OutHigh,
   output logic                   SC_LEVELUP_celebrate_OutHigh,
   output logic                   SC_LEVELUP_gameWon_OutHigh
);

   localparam logic [ROW_WIDTH-1:0] GOAL_VALUE  = ROW_WIDTH'(GOAL_ROW);
   localparam logic [ROW_WIDTH-1:0] START_VALUE = ROW_WIDTH'(START_ROW);

   // A shared goal/start row would let the frog re-arm without ever leaving the goal.
   generate
      if (GOAL_ROW == START_ROW) begin : gIllegalRows
         $error("level_up_detector: GOAL_ROW must differ from START_ROW");
      end
      if (HOLD_CYCLES < 1 || longint'(HOLD_CYCLES) > ((longint'(1) << HOLD_WIDTH) - 1)) begin : gIllegalHold
         $error("level_up_detector: HOLD_CYCLES outside 1..2^HOLD_WIDTH-1");
      end
   endgenerate

   levelState_t stateReg;
   levelState_t stateNext;
   logic        atGoal;
   logic        atStart;
   logic        levelMax;
   logic        timerDone;

   assign atGoal   = SC_LEVELUP_frogAlive_InHigh && (SC_LEVELUP_frogRow_InBUS == GOAL_VALUE);
   assign atStart  = (SC_LEVELUP_frogRow_InBUS == START_VALUE);
   assign levelMax = &SC_LEVELUP_level_InBUS;

   level_hold_timer #(
      .HOLD_CYCLES (HOLD_CYCLES),
      .HOLD_WIDTH  (HOLD_WIDTH)
   ) holdTimer (
      .SC_HOLDTIMER_CLOCK_50      (SC_LEVELUP_CLOCK_50),
      .SC_HOLDTIMER_RESET_InHigh  (SC_LEVELUP_RESET_InHigh),
      .SC_HOLDTIMER_clear_InHigh  ((stateReg != HOLD) || !atGoal),
      .SC_HOLDTIMER_enable_InHigh ((stateReg == HOLD) && !timerDone),
      .SC_HOLDTIMER_done_OutHigh  (timerDone)
   );

   always_ff @(posedge SC_LEVELUP_CLOCK_50) begin
      if (SC_LEVELUP_RESET_InHigh) begin
         stateReg <= IDLE;
      end else begin
         stateReg <= stateNext;
      end
   end

   // NOTE: default assignment first so no branch leaves stateNext unassigned (no latch).
   always_comb begin
      stateNext = stateReg;
      case (stateReg)
         IDLE:    if (atGoal) stateNext = HOLD;
         HOLD: begin
            if (!atGoal) begin
               stateNext = IDLE;
            end else if (timerDone) begin
               stateNext = levelMax ? WON : PULSE;
            end
         end
         PULSE:   stateNext = RESPAWN;
         RESPAWN: if (atStart) stateNext = IDLE;
         WON:     stateNext = WON;
         default: stateNext = IDLE;
      endcase
   end

   always_comb begin
      SC_LEVELUP_upcount_OutLow      = 1'b1;
      SC_LEVELUP_frogRestart_OutHigh = 1'b0;
      SC_LEVELUP_celebrate_OutHigh   = 1'b0;
      SC_LEVELUP_gameWon_OutHigh     = 1'b0;
      case (stateReg)
         HOLD:    SC_LEVELUP_celebrate_OutHigh = 1'b1;
         PULSE: begin
            SC_LEVELUP_upcount_OutLow      = 1'b0;
            SC_LEVELUP_frogRestart_OutHigh = 1'b1;
         end
         RESPAWN: SC_LEVELUP_frogRestart_OutHigh = 1'b1;
         WON:     SC_LEVELUP_gameWon_OutHigh = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_level_up_detector.sv
// Bench for level_up_detector: directed vector table, hand-written corner sequences
// and a randomized run against a cycle-count reference model (HOLD_CYCLES 4 and 1).
module tb_level_up_detector;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] row;
   logic       alive;
   logic [1:0] level;

   logic up4, restart4, cel4, won4;
   logic up1, restart1, cel1, won1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   level_up_detector #(
      .ROW_WIDTH(4), .GOAL_ROW(0), .START_ROW(15),
      .HOLD_CYCLES(4), .HOLD_WIDTH(25), .LEVEL_WIDTH(2)
   ) dut4 (
      .SC_LEVELUP_CLOCK_50            (clk),
      .SC_LEVELUP_RESET_InHigh        (rst),
      .SC_LEVELUP_frogRow_InBUS       (row),
      .SC_LEVELUP_frogAlive_InHigh    (alive),
      .SC_LEVELUP_level_InBUS         (level),
      .SC_LEVELUP_upcount_OutLow      (up4),
      .SC_LEVELUP_frogRestart_OutHigh (restart4),
      .SC_LEVELUP_celebrate_OutHigh   (cel4),
      .SC_LEVELUP_gameWon_OutHigh     (won4)
   );

   level_up_detector #(
      .ROW_WIDTH(4), .GOAL_ROW(0), .START_ROW(15),
      .HOLD_CYCLES(1), .HOLD_WIDTH(25), .LEVEL_WIDTH(2)
   ) dut1 (
      .SC_LEVELUP_CLOCK_50            (clk),
      .SC_LEVELUP_RESET_InHigh        (rst),
      .SC_LEVELUP_frogRow_InBUS       (row),
      .SC_LEVELUP_frogAlive_InHigh    (alive),
      .SC_LEVELUP_level_InBUS         (level),
      .SC_LEVELUP_upcount_OutLow      (up1),
      .SC_LEVELUP_frogRestart_OutHigh (restart1),
      .SC_LEVELUP_celebrate_OutHigh   (cel1),
      .SC_LEVELUP_gameWon_OutHigh     (won1)
   );

   // Output vectors are packed as {upcount, frogRestart, celebrate, gameWon}.
   typedef struct {
      logic       rst;
      logic [3:0] row;
      logic       alive;
      logic [1:0] level;
      logic [3:0] expOut;
   } vector_t;

   typedef struct {
      int holdCount;   // cycles spent celebrating so far, 0 when not holding
      bit pulseNow;
      bit waiting;     // respawn requested, waiting for the start row
      bit won;
   } model_t;

   vector_t vecs[16];
   model_t  m4, m1;

   function automatic vector_t vec(logic r, logic [3:0] rw, logic a, logic [1:0] l, logic [3:0] e);
      vector_t v;
      v.rst = r; v.row = rw; v.alive = a; v.level = l; v.expOut = e;
      return v;
   endfunction

   function automatic model_t modelStep(model_t s, int hold, logic r, logic [3:0] rw, logic a, logic [1:0] l);
      model_t n = s;
      bit goal = a && (rw == 4'd0);
      if (r) begin
         n = '{holdCount: 0, pulseNow: 0, waiting: 0, won: 0};
      end else if (s.won) begin
         n.won = 1;
      end else if (s.pulseNow) begin
         n.pulseNow = 0;
         n.waiting  = 1;
      end else if (s.waiting) begin
         if (rw == 4'd15) n.waiting = 0;
      end else if (s.holdCount > 0) begin
         if (!goal) begin
            n.holdCount = 0;
         end else if (s.holdCount == hold) begin
            n.holdCount = 0;
            if (l == 2'b11) n.won = 1;
            else            n.pulseNow = 1;
         end else begin
            n.holdCount = s.holdCount + 1;
         end
      end else if (goal) begin
         n.holdCount = 1;
      end
      return n;
   endfunction

   function automatic logic [3:0] modelOut(model_t s);
      return {!s.pulseNow, s.pulseNow || s.waiting, s.holdCount > 0, s.won};
   endfunction

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got %0b, expected %0b", name, actual, expected);
      end
   endtask

   task automatic drive(input logic r, input logic [3:0] rw, input logic a, input logic [1:0] l);
      rst = r; row = rw; alive = a; level = l;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int pulses;
      int latency;

      drive(1'b1, 4'd15, 1'b1, 2'd1);

      // Reset, a full level-up with respawn, then an aborted hold.
      vecs[0]  = vec(1, 4'd15, 1, 2'd1, 4'b1000);
      vecs[1]  = vec(1, 4'd15, 1, 2'd1, 4'b1000);
      vecs[2]  = vec(0, 4'd15, 1, 2'd1, 4'b1000);
      vecs[3]  = vec(0, 4'd0,  1, 2'd1, 4'b1010);
      vecs[4]  = vec(0, 4'd0,  1, 2'd1, 4'b1010);
      vecs[5]  = vec(0, 4'd0,  1, 2'd1, 4'b1010);
      vecs[6]  = vec(0, 4'd0,  1, 2'd1, 4'b1010);
      vecs[7]  = vec(0, 4'd0,  1, 2'd1, 4'b0100);
      vecs[8]  = vec(0, 4'd0,  1, 2'd1, 4'b1100);
      vecs[9]  = vec(0, 4'd5,  1, 2'd1, 4'b1100);
      vecs[10] = vec(0, 4'd15, 1, 2'd1, 4'b1000);
      vecs[11] = vec(0, 4'd0,  1, 2'd1, 4'b1010);
      vecs[12] = vec(0, 4'd0,  1, 2'd1, 4'b1010);
      vecs[13] = vec(0, 4'd0,  0, 2'd1, 4'b1000);
      vecs[14] = vec(0, 4'd0,  0, 2'd1, 4'b1000);
      vecs[15] = vec(0, 4'd7,  1, 2'd1, 4'b1000);

      for (int i = 0; i < 16; i++) begin
         drive(vecs[i].rst, vecs[i].row, vecs[i].alive, vecs[i].level);
         tick();
         check($sformatf("vec%0d", i), {up4, restart4, cel4, won4}, vecs[i].expOut);
      end

      // Top level reached: game-won instead of a pulse, sticky until reset.
      drive(1, 4'd15, 1, 2'd3); tick();
      drive(0, 4'd0, 1, 2'd3);
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("wonHold%0d", i), {up4, restart4, cel4, won4}, 4'b1010);
      end
      tick();
      check("wonEnter", {up4, restart4, cel4, won4}, 4'b1001);
      for (int i = 0; i < 10; i++) begin
         drive(0, 4'($urandom), 1'($urandom), 2'($urandom));
         tick();
         check($sformatf("wonSticky%0d", i), {up4, restart4, cel4, won4}, 4'b1001);
      end
      drive(1, 4'd0, 1, 2'd3); tick();
      check("wonReset", {up4, restart4, cel4, won4}, 4'b1000);

      // Frog parked on the goal: one pulse only, re-armed by the start row.
      drive(0, 4'd0, 1, 2'd1);
      pulses = 0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (up4 === 1'b0) pulses++;
      end
      check("singlePulse", pulses, 1);
      drive(0, 4'd15, 1, 2'd1); tick();
      check("rearm", {up4, restart4, cel4, won4}, 4'b1000);
      drive(0, 4'd0, 1, 2'd1);
      latency = 0;
      for (int i = 1; i <= 10 && latency == 0; i++) begin
         tick();
         if (up4 === 1'b0) latency = i;
      end
      check("repulseLatency", latency, 5);

      // Reset in the middle of HOLD and of RESPAWN.
      drive(1, 4'd0, 1, 2'd1); tick();
      drive(0, 4'd0, 1, 2'd1); tick(); tick();
      check("preResetHold", {up4, restart4, cel4, won4}, 4'b1010);
      drive(1, 4'd0, 1, 2'd1); tick();
      check("resetInHold", {up4, restart4, cel4, won4}, 4'b1000);
      drive(0, 4'd0, 1, 2'd1);
      for (int i = 0; i < 6; i++) tick();
      check("preResetRespawn", {up4, restart4, cel4, won4}, 4'b1100);
      drive(1, 4'd0, 1, 2'd1); tick();
      check("resetInRespawn", {up4, restart4, cel4, won4}, 4'b1000);

      // Single-cycle hold variant.
      drive(0, 4'd0, 1, 2'd1); tick();
      check("h1Hold", {up1, restart1, cel1, won1}, 4'b1010);
      tick();
      check("h1Pulse", {up1, restart1, cel1, won1}, 4'b0100);
      tick();
      check("h1Respawn", {up1, restart1, cel1, won1}, 4'b1100);

      // Randomized run against the reference model, both hold lengths.
      m4 = '{holdCount: 0, pulseNow: 0, waiting: 0, won: 0};
      m1 = m4;
      for (int i = 0; i < 3000; i++) begin
         logic       r;
         logic [3:0] rw;
         logic       a;
         logic [1:0] l;
         int         pick;
         r  = (i == 0) || ($urandom_range(199) == 0);
         rw = row;
         if ($urandom_range(3) == 0) begin
            pick = $urandom_range(9);
            rw = (pick < 5) ? 4'd0 : (pick < 8) ? 4'd15 : 4'($urandom);
         end
         a = ($urandom_range(19) != 0);
         l = ($urandom_range(7) == 0) ? 2'($urandom) : level;
         drive(r, rw, a, l);
         m4 = modelStep(m4, 4, r, rw, a, l);
         m1 = modelStep(m1, 1, r, rw, a, l);
         tick();
         check($sformatf("rand%0d_h4", i), {up4, restart4, cel4, won4}, modelOut(m4));
         check($sformatf("rand%0d_h1", i), {up1, restart1, cel1, won1}, modelOut(m1));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/level_up_detector.md
Name: level_up_detector

Overview:
- Upstream stage of the Frogger level counter.
- Watches the frog's row. When the frog reaches the goal row and stays there alive for a hold time, it emits exactly one active-low upcount pulse to the level counter and requests a frog respawn.
- If the counter is already at its maximum level, it raises a sticky game-won flag instead of pulsing, so the level never wraps.

Parameters:
- ROW_WIDTH, 4, width of the frog row bus.
- GOAL_ROW, 0, row index that counts as reaching the goal.
- START_ROW, 15, respawn row; re-arming requires the frog to be seen here.
- HOLD_CYCLES, 25000000, cycles the frog must stay at the goal (0.5 s at 50 MHz); legal range 1..2^HOLD_WIDTH-1.
- HOLD_WIDTH, 25, width of the hold timer.
- LEVEL_WIDTH, 2, width of the level feedback bus; must match the level counter's data width.

Ports:
- SC_LEVELUP_CLOCK_50  in  1  system clock, 50 MHz; the only clock.
- SC_LEVELUP_RESET_InHigh  in  1  synchronous, active-high reset.
- SC_LEVELUP_frogRow_InBUS  in  ROW_WIDTH  current frog row.
- SC_LEVELUP_frogAlive_InHigh  in  1  frog is alive.
- SC_LEVELUP_level_InBUS  in  LEVEL_WIDTH  current level, fed back from the level counter output.
- SC_LEVELUP_upcount_OutLow  out  1  one-cycle low pulse; drives the counter's upcount_InLow input.
- SC_LEVELUP_frogRestart_OutHigh  out  1  respawn request to the frog controller.
- SC_LEVELUP_celebrate_OutHigh  out  1  high while the hold timer runs (display effect).
- SC_LEVELUP_gameWon_OutHigh  out  1  sticky final-win flag.

Behaviour:
- Reset: one clock, synchronous, active-high. On any edge with reset=1:
  - state=IDLE, timer=0;
  - upcount=1, frogRestart=0, celebrate=0, gameWon=0.
  - Reset overrides every state, including mid-HOLD, mid-PULSE and WON.
- Outputs are Moore, decoded from the registered state only:
  - upcount=0 only in PULSE;
  - frogRestart=1 in PULSE and RESPAWN;
  - celebrate=1 only in HOLD;
  - gameWon=1 only in WON.
- IDLE:
  - If row==GOAL_ROW and alive=1 at an edge: go to HOLD, timer<=0.
  - Otherwise stay in IDLE.
- HOLD:
  - If alive=0 or row!=GOAL_ROW: go to IDLE (abort, no pulse).
  - Else if timer==HOLD_CYCLES-1: go to WON when level is all ones, otherwise go to PULSE.
  - Else timer<=timer+1.
  - HOLD lasts exactly HOLD_CYCLES cycles; with HOLD_CYCLES=1 it lasts one cycle.
- PULSE: lasts exactly one cycle, then unconditionally RESPAWN.
- RESPAWN:
  - Hold frogRestart=1 until row==START_ROW, then go to IDLE.
  - Level-ups never repeat while the frog is still at the goal.
  - alive is ignored in this state.
- WON: absorbing; left only by reset. upcount stays 1.
- Latency: goal condition first true at edge N gives HOLD during cycles N..N+HOLD_CYCLES-1, and upcount low during cycle N+HOLD_CYCLES only.
- Boundary cases:
  - GOAL_ROW==START_ROW is illegal; flag it with a static check.
  - The timer never exceeds HOLD_CYCLES-1.
  - Level feedback is sampled only at the HOLD-exit edge.

Decomposition:
- Shared package level_pkg holds:
  - state encoding localparams IDLE, HOLD, PULSE, RESPAWN, WON (3 bits);
  - LEVEL_WIDTH default, kept common with the level counter.
- Natural sub-module: level_hold_timer.
  - A HOLD_WIDTH-bit counter with synchronous clear and enable.
  - Outputs a done flag when the count equals HOLD_CYCLES-1.
- The FSM and output decode stay in the top module.

Test Plan (HOLD_CYCLES=4 unless stated):
- Reset for 2 cycles, row=15, alive=1 -> upcount=1, frogRestart=0, celebrate=0, gameWon=0; FSM stays IDLE.
- Row=0, alive=1 from edge N, level=1 -> celebrate=1 for cycles N..N+3; upcount=0 only in cycle N+4; frogRestart=1 from N+4 until row=15 is seen, then 0.
- Row=0 for 2 cycles, then alive=0 -> celebrate drops; FSM returns to IDLE; upcount never goes low.
- Level=3 (all ones), frog holds at goal 4 cycles -> no upcount pulse; gameWon=1 and stays 1 with row/alive toggling; cleared only by reset.
- Frog stays at row 0 after PULSE for 20 cycles -> exactly one upcount pulse; after row=15 then row=0 again, a second pulse follows 5 cycles later.
- Reset asserted during HOLD and during RESPAWN -> all outputs return to reset values at the next edge; HOLD_CYCLES=1 variant gives upcount low exactly 1 cycle after HOLD.
